nms_stage: RTL

- Canny non-maximum suppression stage, directly downstream of the Sobel gradient stage.
- Consumes the raster-order stream of {direction[2:0], magnitude[11:0]} words and keeps a pixel's magnitude only if it is a local maximum along its quantised gradient axis; otherwise outputs 0.
- Emits one 8-bit thinned magnitude per input pixel, in raster order, with tlast on the final pixel of each frame. Feeds the hysteresis/threshold stage.

---
 rtl/nms_stage.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/nms_stage.sv
// Canny non-maximum suppression: keeps a pixel's clamped magnitude only when it is a
// local maximum along its quantised gradient axis; streams one thinned byte per pixel.
module nms_stage #(
   parameter int unsigned IMG_WIDTH  = 128,
   parameter int unsigned IMG_HEIGHT = 128,
   parameter int unsigned THRESH     = 0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [14:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        frame_err
);

   localparam int unsigned W     = IMG_WIDTH;
   localparam int unsigned H     = IMG_HEIGHT;
   localparam int unsigned NPIX  = W * H;
   localparam int unsigned NSTEP = NPIX + W + 1;
   localparam int unsigned CNT_W = $clog2(NSTEP);
   localparam int unsigned COL_W = (W > 1) ? $clog2(W) : 1;
   localparam int unsigned ROW_W = (H > 1) ? $clog2(H) : 1;

   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(W);
   localparam logic [CNT_W-1:0] LAST_IN   = CNT_W'(NPIX - 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEP - 1);
   localparam logic [COL_W-1:0] COL_MAX   = COL_W'(W - 1);
   localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(H - 1);

   typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;
   state_t state, state_nx;

   logic [CNT_W-1:0] pix_cnt;
   logic [COL_W-1:0] in_col, out_col;
   logic [ROW_W-1:0] out_row;

   logic slot, in_fire, step, produce, frame_end;
   logic [9:0] in_word, step_word;
   logic dir_msb_unused;

   logic [9:0] lb1 [W];
   logic [7:0] lb2 [W];
   logic [9:0] lb1_rd;
   logic [7:0] lb2_rd;

   logic [2:0][7:0] col_a, col_b, col_c;
   logic [1:0]      b_axis;

   logic       top_ok, bot_ok, left_ok, right_ok, keep;
   logic [7:0] c_mag, n1, n2;

   assign slot          = m_axis_tready || !m_axis_tvalid;
   assign s_axis_tready = slot && (state != FLUSH);
   assign in_fire       = s_axis_tvalid && s_axis_tready;
   assign step          = in_fire || (slot && (state == FLUSH));
   assign produce       = step && (pix_cnt > FILL_LAST);
   assign frame_end     = step && (pix_cnt == LAST_STEP);

   assign dir_msb_unused = s_axis_tdata[14];
   assign in_word   = {s_axis_tdata[13:12], (|s_axis_tdata[11:8]) ? 8'hFF : s_axis_tdata[7:0]};
   assign step_word = (state == FLUSH) ? '0 : in_word;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= FILL;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         FILL: begin
            if (in_fire) begin
               if (pix_cnt == LAST_IN)        state_nx = FLUSH;
               else if (pix_cnt == FILL_LAST) state_nx = STREAM;
            end
         end
         STREAM: if (in_fire && pix_cnt == LAST_IN) state_nx = FLUSH;
         FLUSH:  if (frame_end) state_nx = FILL;
         default: state_nx = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pix_cnt <= '0;
         in_col  <= '0;
         out_col <= '0;
         out_row <= '0;
      end else if (frame_end) begin
         pix_cnt <= '0;
         in_col  <= '0;
         out_col <= '0;
         out_row <= '0;
      end else if (step) begin
         pix_cnt <= pix_cnt + 1'b1;
         in_col  <= (in_col == COL_MAX) ? '0 : in_col + 1'b1;
         if (produce) begin
            if (out_col == COL_MAX) begin
               out_col <= '0;
               out_row <= out_row + 1'b1;
            end else begin
               out_col <= out_col + 1'b1;
            end
         end
      end
   end

   // Line buffers hold rows r and r-1 of the centre; stale contents are always masked
   assign lb1_rd = lb1[in_col];
   assign lb2_rd = lb2[in_col];

   always_ff @(posedge clk) begin
      if (step) begin
         lb1[in_col] <= step_word;
         lb2[in_col] <= lb1_rd[7:0];
      end
   end

   // col_c is the incoming column c+1 (rows r-1, r, r+1); it is never registered before use
   assign col_c = {step_word[7:0], lb1_rd[7:0], lb2_rd};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         col_a  <= '0;
         col_b  <= '0;
         b_axis <= '0;
      end else if (step) begin
         col_a  <= col_b;
         col_b  <= col_c;
         b_axis <= lb1_rd[9:8];
      end
   end

   assign top_ok   = (out_row != '0);
   assign bot_ok   = (out_row != ROW_MAX);
   assign left_ok  = (out_col != '0);
   assign right_ok = (out_col != COL_MAX);
   assign c_mag    = col_b[1];

   always_comb begin
      n1 = '0;
      n2 = '0;
      case (b_axis)
         2'd0: begin
            n1 = left_ok  ? col_a[1] : '0;
            n2 = right_ok ? col_c[1] : '0;
         end
         2'd1: begin
            n1 = (left_ok && top_ok)  ? col_a[0] : '0;
            n2 = (right_ok && bot_ok) ? col_c[2] : '0;
         end
         2'd2: begin
            n1 = top_ok ? col_b[0] : '0;
            n2 = bot_ok ? col_b[2] : '0;
         end
         default: begin
            n1 = (right_ok && top_ok) ? col_c[0] : '0;
            n2 = (left_ok && bot_ok)  ? col_a[2] : '0;
         end
      endcase
   end

   assign keep = (c_mag >= n1) && (c_mag >= n2) && (32'(c_mag) > THRESH);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else if (produce) begin
         m_axis_tdata  <= keep ? c_mag : '0;
         m_axis_tvalid <= 1'b1;
         m_axis_tlast  <= (out_row == ROW_MAX) && (out_col == COL_MAX);
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) frame_err <= 1'b0;
      else         frame_err <= in_fire && (s_axis_tlast != (pix_cnt == LAST_IN));
   end

endmodule
